// File: rtl/stage_pkg.sv
// Shared encodings for the linked-session stage controller: FSM states and board roles.
package stage_pkg;

    typedef enum logic [2:0] {
        SMENU  = 3'd0,
        SCOUNT = 3'd1,
        SGAME  = 3'd2,
        SPAUSE = 3'd3,
        SOVER  = 3'd4
    } stage_e;

    localparam logic MASTER = 1'b0;
    localparam logic SLAVE  = 1'b1;

    // States in which the link-loss watchdog may run.
    function automatic logic is_play(input stage_e s);
        return (s == SCOUNT) || (s == SGAME) || (s == SPAUSE);
    endfunction

endpackage

// File: rtl/click_pulse.sv
// Registered falling-edge detector: one-cycle pulse the cycle after a 1->0 level is sampled.
module click_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level_q & ~level;
        end
    end

endmodule

// File: rtl/stage_controller.sv
// Game-flow FSM for an N-peer linked session: menu, countdown, play, pause, game over,
// with link-synchronised start/pause and a link-loss watchdog.
module stage_controller
    import stage_pkg::*;
#(
    parameter int NUM_PEERS     = 2,
    parameter int COUNTDOWN_CYC = 3,
    parameter int TIMEOUT_CYC   = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mouse_left,
    input  logic                 on_start_btn,
    input  logic                 on_connect_btn,
    input  logic                 on_pause_btn,
    input  logic                 on_return_btn,
    input  logic                 game_finish,
    input  logic [NUM_PEERS-1:0] receive_connect,
    input  logic [NUM_PEERS-1:0] receive_start,
    input  logic [NUM_PEERS-1:0] receive_pause,
    input  logic [NUM_PEERS-1:0] receive_game_finish,
    output logic [2:0]           state,
    output logic                 game_init,
    output logic                 send_connect,
    output logic                 send_start,
    output logic                 send_pause,
    output logic                 role,
    output logic [NUM_PEERS-1:0] peers_live,
    output logic [CNT_W-1:0]     countdown,
    output logic                 link_lost
);

    stage_e           state_q;
    stage_e           state_nx;
    logic             click;
    logic [CNT_W-1:0] tcnt_q;
    logic             armed_q;

    click_pulse u_click (
        .clk   (clk),
        .reset (reset),
        .level (mouse_left),
        .pulse (click)
    );

    logic start_click, connect_click, pause_click, return_click;
    logic any_live, remote_start, remote_pause, remote_finish;
    logic wd_active, timeout_fire, entering_count;

    assign start_click   = click & on_start_btn;
    assign connect_click = click & on_connect_btn;
    assign pause_click   = click & on_pause_btn;
    assign return_click  = click & on_return_btn;

    // Masking by send_connect makes every receive_* input inert during unlinked play.
    assign peers_live    = receive_connect & {NUM_PEERS{send_connect}};
    assign any_live      = |peers_live;
    assign remote_start  = |(peers_live & receive_start);
    assign remote_pause  = |(peers_live & receive_pause);
    assign remote_finish = |(peers_live & receive_game_finish);

    assign wd_active      = is_play(state_q) & armed_q & send_connect;
    assign timeout_fire   = wd_active & ~any_live & (tcnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign entering_count = (state_q == SMENU) && (state_nx == SCOUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= SMENU;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            SMENU: begin
                if ((role == MASTER && start_click) || (role == SLAVE && remote_start))
                    state_nx = SCOUNT;
            end
            SCOUNT: begin
                if (timeout_fire)                      state_nx = SOVER;
                else if (countdown == CNT_W'(1))       state_nx = SGAME;
            end
            SGAME: begin
                if (timeout_fire || game_finish || remote_finish) state_nx = SOVER;
                else if (pause_click || remote_pause)             state_nx = SPAUSE;
            end
            SPAUSE: begin
                if (timeout_fire)                          state_nx = SOVER;
                else if (return_click)                     state_nx = SMENU;
                else if (!send_pause && !remote_pause)     state_nx = SGAME;
            end
            SOVER: begin
                if (return_click) state_nx = SMENU;
            end
            default: state_nx = SMENU;
        endcase
    end

    always_comb begin
        state = state_q;
        case (state_q)
            SGAME, SPAUSE: game_init = 1'b0;
            default:       game_init = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_connect <= 1'b0;
            send_start   <= 1'b0;
            send_pause   <= 1'b0;
            role         <= MASTER;
            countdown    <= '0;
            link_lost    <= 1'b0;
            tcnt_q       <= '0;
            armed_q      <= 1'b0;
        end else begin
            // Role is decided at the moment of connecting: a peer already present makes us slave.
            if (state_q == SMENU && connect_click) begin
                send_connect <= ~send_connect;
                role         <= (!send_connect && (|receive_connect)) ? SLAVE : MASTER;
            end

            if (entering_count && role == MASTER)                 send_start <= 1'b1;
            else if (state_nx == SMENU || state_nx == SOVER)      send_start <= 1'b0;

            if (state_nx == SMENU || state_nx == SOVER)           send_pause <= 1'b0;
            else if (state_q == SGAME && state_nx == SPAUSE && pause_click)
                                                                  send_pause <= 1'b1;
            else if (state_q == SPAUSE && pause_click)            send_pause <= 1'b0;

            if (entering_count)               countdown <= CNT_W'(COUNTDOWN_CYC);
            else if (state_nx == SCOUNT)      countdown <= countdown - CNT_W'(1);
            else                              countdown <= '0;

            if (state_nx == SMENU)            link_lost <= 1'b0;
            else if (timeout_fire)            link_lost <= 1'b1;

            if (entering_count)                               armed_q <= any_live;
            else if (state_nx == SMENU || state_nx == SOVER)  armed_q <= 1'b0;

            if (wd_active && is_play(state_nx) && !any_live)  tcnt_q <= tcnt_q + CNT_W'(1);
            else                                              tcnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_stage_controller.sv
// Directed bench for stage_controller: unlinked flow, slave start, remote/local pause,
// finish priority, link-loss timeout and asynchronous reset.
module tb_stage_controller;

    localparam int NP = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mouse_left = 1'b0;
    logic          on_start_btn = 1'b0, on_connect_btn = 1'b0;
    logic          on_pause_btn = 1'b0, on_return_btn = 1'b0;
    logic          game_finish = 1'b0;
    logic [NP-1:0] receive_connect = '0, receive_start = '0;
    logic [NP-1:0] receive_pause = '0, receive_game_finish = '0;
    logic [2:0]    state;
    logic          game_init, send_connect, send_start, send_pause, role, link_lost;
    logic [NP-1:0] peers_live;
    logic [CW-1:0] countdown;

    int checks = 0;
    int errors = 0;

    stage_controller #(
        .NUM_PEERS(NP), .COUNTDOWN_CYC(3), .TIMEOUT_CYC(8), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(rst_n), .mouse_left(mouse_left),
        .on_start_btn(on_start_btn), .on_connect_btn(on_connect_btn),
        .on_pause_btn(on_pause_btn), .on_return_btn(on_return_btn),
        .game_finish(game_finish), .receive_connect(receive_connect),
        .receive_start(receive_start), .receive_pause(receive_pause),
        .receive_game_finish(receive_game_finish), .state(state),
        .game_init(game_init), .send_connect(send_connect), .send_start(send_start),
        .send_pause(send_pause), .role(role), .peers_live(peers_live),
        .countdown(countdown), .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press/release over a button; the FSM acts on the click at the third edge.
    // with_finish raises game_finish for that same edge.
    task automatic do_click(input int which, input bit with_finish);
        on_start_btn   = (which == 0);
        on_connect_btn = (which == 1);
        on_pause_btn   = (which == 2);
        on_return_btn  = (which == 3);
        mouse_left = 1'b1;
        tick(1);
        mouse_left = 1'b0;
        tick(1);
        if (with_finish) game_finish = 1'b1;
        tick(1);
        game_finish = 1'b0;
        on_start_btn = 1'b0; on_connect_btn = 1'b0; on_pause_btn = 1'b0; on_return_btn = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if ({send_connect, send_start, send_pause, role, link_lost} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {send_connect, send_start, send_pause, role, link_lost}); end
        checks++; if (countdown !== 16'd0 || game_init !== 1'b1) begin
            errors++; $display("FAIL reset_cnt got cd=%0d gi=%0d exp cd=0 gi=1", countdown, game_init); end
    endtask

    task automatic test_unlinked;
        do_click(0, 1'b0);
        checks++; if (state !== 3'd1 || countdown !== 16'd3 || send_start !== 1'b1) begin
            errors++; $display("FAIL un_count0 got st=%0d cd=%0d ss=%0d exp 1/3/1", state, countdown, send_start); end
        tick(1);
        checks++; if (state !== 3'd1 || countdown !== 16'd2) begin
            errors++; $display("FAIL un_count1 got st=%0d cd=%0d exp 1/2", state, countdown); end
        tick(1);
        checks++; if (state !== 3'd1 || countdown !== 16'd1) begin
            errors++; $display("FAIL un_count2 got st=%0d cd=%0d exp 1/1", state, countdown); end
        tick(1);
        checks++; if (state !== 3'd2 || countdown !== 16'd0 || game_init !== 1'b0) begin
            errors++; $display("FAIL un_game got st=%0d cd=%0d gi=%0d exp 2/0/0", state, countdown, game_init); end
        // Remote inputs are inert while not connected.
        receive_connect = 2'b11; receive_pause = 2'b11; receive_game_finish = 2'b11;
        tick(2);
        checks++; if (state !== 3'd2 || peers_live !== 2'b00) begin
            errors++; $display("FAIL un_ignore got st=%0d pl=%b exp 2/00", state, peers_live); end
        receive_connect = '0; receive_pause = '0; receive_game_finish = '0;
        game_finish = 1'b1;
        tick(1);
        game_finish = 1'b0;
        checks++; if (state !== 3'd4 || send_start !== 1'b0 || game_init !== 1'b1) begin
            errors++; $display("FAIL un_over got st=%0d ss=%0d gi=%0d exp 4/0/1", state, send_start, game_init); end
        do_click(3, 1'b0);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL un_return got %0d exp 0", state); end
    endtask

    task automatic test_slave_start;
        receive_connect = 2'b01;
        do_click(1, 1'b0);
        checks++; if (send_connect !== 1'b1 || role !== 1'b1 || peers_live !== 2'b01) begin
            errors++; $display("FAIL sl_connect got sc=%0d role=%0d pl=%b exp 1/1/01", send_connect, role, peers_live); end
        do_click(0, 1'b0);
        checks++; if (state !== 3'd0 || send_start !== 1'b0) begin
            errors++; $display("FAIL sl_click_ignored got st=%0d ss=%0d exp 0/0", state, send_start); end
        receive_start = 2'b10;
        tick(1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL sl_dead_peer_start got %0d exp 0", state); end
        receive_start = 2'b01;
        tick(1);
        receive_start = 2'b00;
        checks++; if (state !== 3'd1 || countdown !== 16'd3 || send_start !== 1'b0) begin
            errors++; $display("FAIL sl_count got st=%0d cd=%0d ss=%0d exp 1/3/0", state, countdown, send_start); end
        receive_connect = 2'b11;
        tick(3);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL sl_game got %0d exp 2", state); end
    endtask

    task automatic test_remote_pause;
        receive_pause = 2'b10;
        tick(1);
        checks++; if (state !== 3'd3 || send_pause !== 1'b0 || game_init !== 1'b0) begin
            errors++; $display("FAIL rp_pause got st=%0d sp=%0d gi=%0d exp 3/0/0", state, send_pause, game_init); end
        tick(2);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL rp_hold got %0d exp 3", state); end
        receive_pause = 2'b00;
        tick(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rp_resume got %0d exp 2", state); end
    endtask

    task automatic test_local_pause;
        do_click(2, 1'b0);
        checks++; if (state !== 3'd3 || send_pause !== 1'b1) begin
            errors++; $display("FAIL lp_pause got st=%0d sp=%0d exp 3/1", state, send_pause); end
        do_click(2, 1'b0);
        checks++; if (state !== 3'd3 || send_pause !== 1'b0) begin
            errors++; $display("FAIL lp_unpause got st=%0d sp=%0d exp 3/0", state, send_pause); end
        tick(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL lp_resume got %0d exp 2", state); end
    endtask

    task automatic test_finish_priority;
        do_click(2, 1'b1);
        checks++; if (state !== 3'd4 || send_pause !== 1'b0) begin
            errors++; $display("FAIL fp_over got st=%0d sp=%0d exp 4/0", state, send_pause); end
        do_click(3, 1'b0);
        checks++; if (state !== 3'd0 || send_connect !== 1'b1 || role !== 1'b1) begin
            errors++; $display("FAIL fp_menu got st=%0d sc=%0d role=%0d exp 0/1/1", state, send_connect, role); end
    endtask

    task automatic test_timeout;
        receive_start = 2'b01;
        tick(1);
        receive_start = 2'b00;
        tick(3);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL to_game got %0d exp 2", state); end
        receive_connect = 2'b00;
        tick(5);
        receive_connect = 2'b10;
        tick(1);
        receive_connect = 2'b00;
        tick(7);
        checks++; if (state !== 3'd2 || link_lost !== 1'b0) begin
            errors++; $display("FAIL to_restart got st=%0d ll=%0d exp 2/0", state, link_lost); end
        tick(1);
        checks++; if (state !== 3'd4 || link_lost !== 1'b1) begin
            errors++; $display("FAIL to_fire got st=%0d ll=%0d exp 4/1", state, link_lost); end
        tick(3);
        checks++; if (link_lost !== 1'b1) begin errors++; $display("FAIL to_sticky got %0d exp 1", link_lost); end
        do_click(3, 1'b0);
        checks++; if (state !== 3'd0 || link_lost !== 1'b0) begin
            errors++; $display("FAIL to_clear got st=%0d ll=%0d exp 0/0", state, link_lost); end
    endtask

    task automatic test_async_reset;
        receive_connect = 2'b01;
        receive_start = 2'b01;
        tick(1);
        receive_start = 2'b00;
        tick(1);
        checks++; if (state !== 3'd1 || countdown !== 16'd2) begin
            errors++; $display("FAIL ar_pre got st=%0d cd=%0d exp 1/2", state, countdown); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || countdown !== 16'd0 || game_init !== 1'b1) begin
            errors++; $display("FAIL ar_state got st=%0d cd=%0d gi=%0d exp 0/0/1", state, countdown, game_init); end
        checks++; if ({send_connect, send_start, send_pause, role, link_lost} !== 5'b0 || peers_live !== 2'b00) begin
            errors++; $display("FAIL ar_flags got %b pl=%b exp 00000/00", {send_connect, send_start, send_pause, role, link_lost}, peers_live); end
        tick(1);
        rst_n = 1'b1;
        receive_connect = 2'b00;
        tick(1);
        do_click(1, 1'b0);
        checks++; if (send_connect !== 1'b1 || role !== 1'b0) begin
            errors++; $display("FAIL ar_master got sc=%0d role=%0d exp 1/0", send_connect, role); end
    endtask

    initial begin
        test_reset();
        test_unlinked();
        test_slave_start();
        test_remote_pause();
        test_local_pause();
        test_finish_priority();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
